// File: rtl/reg_fifo_bank.sv
// reg_fifo_bank: WIDTH x DEPTH flop-based FIFO, valid/ready on both sides,
// first-word-fall-through head. Occupancy drives full/empty; pointers wrap
// freely. Optional peak-occupancy tracking when REG_FIFO_STATS_EN is defined
// (adds the max_count port and its register).
module reg_fifo_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
`ifdef REG_FIFO_STATS_EN
  ,
  output logic [CW-1:0]    max_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               w_count_next;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;

  // Full/empty come from occupancy only; ready never looks at out_ready
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid & !w_full;
  assign w_pop     = out_ready & !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Next occupancy; flush wins over any push/pop in the same cycle
  always_comb begin
    w_count_next = r_count;
    if (flush)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CW'(1);
  end

  // One enabled register per entry; a flushed push is dropped
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic w_we;
    assign w_we = w_push & !flush & (r_wr_ptr == PW'(i));
    // Entry storage, cleared on reset so the idle head reads zero
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)    r_mem[i] <= '0;
      else if (w_we) r_mem[i] <= in_data;
    end
  end

  // Pointer and occupancy state; DEPTH is a power of two so wrap is natural
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

`ifdef REG_FIFO_STATS_EN
  logic [CW-1:0] r_max_count;
  assign max_count = r_max_count;

  // Peak occupancy, restarted by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_max_count <= '0;
    else if (flush)
      r_max_count <= '0;
    else if (w_count_next > r_max_count)
      r_max_count <= w_count_next;
  end
`endif

endmodule
